// File: rtl/zynet_pkg.sv
// Shared zyNet definitions: default result-vector geometry and the serializer state type.
package zynet_pkg;

    localparam int ZYNET_WORD_SIZE   = 16;
    localparam int ZYNET_OUTPUT_SIZE = 10;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/zynet_output_serializer_if.sv
// Result-vector intake (valid/yumi) and word stream (valid/ready) bundle for the serializer.
// Argmax signals exist only when ZYNET_OUTPUT_SERIALIZER_ARGMAX_EN is defined.
interface zynet_output_serializer_if #(
    parameter int WORD_SIZE   = 16,
    parameter int OUTPUT_SIZE = 10
);
    localparam int IDX_W = $clog2(OUTPUT_SIZE);

    logic                                  valid_i;
    logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] data_i;
    logic                                  yumi_o;
    logic                                  valid_o;
    logic                                  ready_i;
    logic [WORD_SIZE-1:0]                  data_o;
    logic [IDX_W-1:0]                      index_o;
    logic                                  last_o;
`ifdef ZYNET_OUTPUT_SERIALIZER_ARGMAX_EN
    logic [IDX_W-1:0]                      argmax_o;
    logic                                  argmax_valid_o;
`endif

    // Serializer side: consumes the vector, produces the stream.
    modport slave (
        input  valid_i, data_i, ready_i,
        output yumi_o, valid_o, data_o, index_o, last_o
`ifdef ZYNET_OUTPUT_SERIALIZER_ARGMAX_EN
        , output argmax_o, argmax_valid_o
`endif
    );

    modport master (
        output valid_i, data_i, ready_i,
        input  yumi_o, valid_o, data_o, index_o, last_o
`ifdef ZYNET_OUTPUT_SERIALIZER_ARGMAX_EN
        , input argmax_o, argmax_valid_o
`endif
    );

endinterface

// File: rtl/zynet_output_serializer_argmax_tracker.sv
// Running signed maximum over a streamed vector; reports the winning index once per vector.
module argmax_tracker #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [WORD_SIZE-1:0] word,
    input  logic [IDX_W-1:0]            index,
    input  logic                        load,
    input  logic                        update,
    input  logic                        done,
    output logic [IDX_W-1:0]            argmax,
    output logic                        argmax_valid
);

    logic signed [WORD_SIZE-1:0] max_reg, max_next;
    logic [IDX_W-1:0]            max_idx_reg, max_idx_next;
    logic [IDX_W-1:0]            argmax_reg;
    logic                        valid_reg;
    logic                        take;

    // Strict compare so equal values keep the earliest index.
    always_comb begin
        take         = load | (update & (word > max_reg));
        max_next     = take ? word  : max_reg;
        max_idx_next = take ? index : max_idx_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_reg     <= '0;
            max_idx_reg <= '0;
            argmax_reg  <= '0;
            valid_reg   <= 1'b0;
        end else begin
            if (load | update) begin
                max_reg     <= max_next;
                max_idx_reg <= max_idx_next;
            end
            if (done) begin
                argmax_reg <= max_idx_next;
            end
            valid_reg <= done;
        end
    end

    assign argmax       = argmax_reg;
    assign argmax_valid = valid_reg;

endmodule

// File: rtl/zynet_output_serializer.sv
// Captures a parallel result vector and replays it one word per valid/ready handshake.
// Define ZYNET_OUTPUT_SERIALIZER_ARGMAX_EN to add the signed argmax tracker.
module zynet_output_serializer
    import zynet_pkg::*;
#(
    parameter int WORD_SIZE   = ZYNET_WORD_SIZE,
    parameter int OUTPUT_SIZE = ZYNET_OUTPUT_SIZE
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    zynet_output_serializer_if.slave      bus
);

    localparam int               IDX_W    = $clog2(OUTPUT_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [WORD_SIZE-1:0] word_buf_reg [OUTPUT_SIZE];

    logic stream_valid;
    logic at_last;
    logic handshake;
    logic yumi;

    always_comb begin
        stream_valid = (state_reg == STREAM);
        at_last      = (idx_reg == LAST_IDX);
        handshake    = stream_valid & bus.ready_i;
        yumi         = 1'b0;
        state_next   = state_reg;
        idx_next     = idx_reg;
        case (state_reg)
            IDLE: begin
                yumi = bus.valid_i;
                if (yumi) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                // A waiting vector is only taken on the final handshake, so no bubble.
                yumi = bus.valid_i & handshake & at_last;
                if (handshake && at_last && !yumi) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (yumi) begin
            idx_next = '0;
        end else if (handshake) begin
            idx_next = at_last ? '0 : idx_reg + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    generate
        for (genvar gi = 0; gi < OUTPUT_SIZE; gi++) begin : g_word_buf
            always_ff @(posedge clk_i or negedge reset_i) begin
                if (!reset_i) begin
                    word_buf_reg[gi] <= '0;
                end else if (yumi) begin
                    word_buf_reg[gi] <= bus.data_i[gi];
                end
            end
        end
    endgenerate

    // Gating with reset keeps yumi low while the asynchronous reset is held.
    assign bus.yumi_o  = yumi & reset_i;
    assign bus.valid_o = stream_valid;
    assign bus.data_o  = word_buf_reg[idx_reg];
    assign bus.index_o = idx_reg;
    assign bus.last_o  = stream_valid & at_last;

`ifdef ZYNET_OUTPUT_SERIALIZER_ARGMAX_EN
    argmax_tracker #(
        .WORD_SIZE (WORD_SIZE),
        .IDX_W     (IDX_W)
    ) u_argmax_tracker (
        .clk          (clk_i),
        .rst_n        (reset_i),
        .word         (word_buf_reg[idx_reg]),
        .index        (idx_reg),
        .load         (handshake & (idx_reg == '0)),
        .update       (handshake & (idx_reg != '0)),
        .done         (handshake & at_last),
        .argmax       (bus.argmax_o),
        .argmax_valid (bus.argmax_valid_o)
    );
`endif

endmodule

// File: tb/tb_zynet_output_serializer.sv
// Directed bench for zynet_output_serializer: single vector, backpressure, back-to-back, mid-stream reset.
module tb_zynet_output_serializer;

    localparam int WS = 16;
    localparam int OS = 10;

    logic clk;
    logic reset_i;
    int   total = 0;
    int   bad   = 0;

    zynet_output_serializer_if #(.WORD_SIZE(WS), .OUTPUT_SIZE(OS)) bus ();

    zynet_output_serializer #(.WORD_SIZE(WS), .OUTPUT_SIZE(OS)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor, sampled at the rising edge before registers update.
    logic prev_valid = 1'b0;
    logic prev_hs    = 1'b0;
    always @(posedge clk) begin
        if (reset_i) begin
            total++;
            if (bus.yumi_o && !bus.valid_i) begin
                bad++;
                $display("FAIL proto_yumi yumi_o=%0b while valid_i=%0b", bus.yumi_o, bus.valid_i);
            end
            if (prev_valid && !prev_hs) begin
                total++;
                if (bus.valid_o !== 1'b1) begin
                    bad++;
                    $display("FAIL proto_valid_drop valid_o=%0b required=1", bus.valid_o);
                end
            end
            prev_valid <= bus.valid_o;
            prev_hs    <= bus.valid_o & bus.ready_i;
        end else begin
            prev_valid <= 1'b0;
            prev_hs    <= 1'b0;
        end
    end

    task automatic test_reset();
        reset_i     = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.data_i  = '0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (bus.valid_o !== 1'b0 || bus.yumi_o !== 1'b0 || bus.last_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl valid_o=%0b yumi_o=%0b last_o=%0b required 0 0 0",
                     bus.valid_o, bus.yumi_o, bus.last_o);
        end
        total++;
        if (bus.data_o !== 16'd0 || bus.index_o !== 4'd0) begin
            bad++;
            $display("FAIL reset_data data_o=%0d index_o=%0d required 0 0", bus.data_o, bus.index_o);
        end
`ifdef ZYNET_OUTPUT_SERIALIZER_ARGMAX_EN
        total++;
        if (bus.argmax_o !== 4'd0 || bus.argmax_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_argmax argmax_o=%0d argmax_valid_o=%0b required 0 0",
                     bus.argmax_o, bus.argmax_valid_o);
        end
`endif
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release valid_o=%0b required 0", bus.valid_o);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        @(negedge clk);
        for (int k = 0; k < OS; k++) bus.data_i[k] = WS'(k);
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        #1;
        total++;
        if (bus.yumi_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL single_accept yumi_o=%0b valid_o=%0b required 1 0", bus.yumi_o, bus.valid_o);
        end
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.data_i  = '1;
        for (int k = 0; k < OS; k++) begin
            #1;
            total++;
            if (bus.valid_o !== 1'b1 || bus.data_o !== WS'(k) || bus.index_o !== 4'(k) ||
                bus.last_o !== (k == OS - 1)) begin
                bad++;
                $display("FAIL single_word%0d valid=%0b data=%0d idx=%0d last=%0b required 1 %0d %0d %0b",
                         k, bus.valid_o, bus.data_o, bus.index_o, bus.last_o, k, k, (k == OS - 1));
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (bus.valid_o !== 1'b0 || bus.last_o !== 1'b0) begin
            bad++;
            $display("FAIL single_idle valid_o=%0b last_o=%0b required 0 0", bus.valid_o, bus.last_o);
        end
        $display("test_single done");
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        int k = 0;
        int cycles = 0;
        @(negedge clk);
        for (int i = 0; i < OS; i++) bus.data_i[i] = WS'(100 + i);
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        while (k < OS && cycles < 60) begin
            bus.ready_i = pat[cycles % 4];
            #1;
            total++;
            if (bus.valid_o !== 1'b1 || bus.data_o !== WS'(100 + k) || bus.index_o !== 4'(k) ||
                bus.last_o !== (k == OS - 1)) begin
                bad++;
                $display("FAIL bp_cycle%0d valid=%0b data=%0d idx=%0d last=%0b required 1 %0d %0d %0b",
                         cycles, bus.valid_o, bus.data_o, bus.index_o, bus.last_o, 100 + k, k, (k == OS - 1));
            end
            if (bus.ready_i) k++;
            cycles++;
            @(negedge clk);
        end
        bus.ready_i = 1'b1;
        total++;
        if (k != OS) begin
            bad++;
            $display("FAIL bp_handshakes got=%0d required=%0d (cycle budget expired)", k, OS);
        end
        #1;
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_idle valid_o=%0b required 0", bus.valid_o);
        end
        $display("test_backpressure done handshakes=%0d cycles=%0d", k, cycles);
    endtask

    task automatic test_back_to_back();
        int exp_data;
        @(negedge clk);
        for (int i = 0; i < OS; i++) bus.data_i[i] = WS'(200 + i);
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        #1;
        total++;
        if (bus.yumi_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept_a yumi_o=%0b required 1", bus.yumi_o);
        end
        @(negedge clk);
        for (int i = 0; i < OS; i++) bus.data_i[i] = WS'(300 + i);
        for (int n = 0; n < 2 * OS; n++) begin
            if (n == OS) bus.valid_i = 1'b0;
            exp_data = (n < OS) ? 200 + n : 300 + n - OS;
            #1;
            total++;
            if (bus.valid_o !== 1'b1 || bus.data_o !== WS'(exp_data) || bus.index_o !== 4'(n % OS) ||
                bus.yumi_o !== (n == OS - 1)) begin
                bad++;
                $display("FAIL b2b_cycle%0d valid=%0b data=%0d idx=%0d yumi=%0b required 1 %0d %0d %0b",
                         n, bus.valid_o, bus.data_o, bus.index_o, bus.yumi_o, exp_data, n % OS, (n == OS - 1));
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle valid_o=%0b required 0", bus.valid_o);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        for (int i = 0; i < OS; i++) bus.data_i[i] = WS'(50 + i);
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (bus.data_o !== WS'(50 + k) || bus.index_o !== 4'(k)) begin
                bad++;
                $display("FAIL mid_word%0d data=%0d idx=%0d required %0d %0d",
                         k, bus.data_o, bus.index_o, 50 + k, k);
            end
            @(negedge clk);
        end
        reset_i = 1'b0;
        #1;
        total++;
        if (bus.valid_o !== 1'b0 || bus.yumi_o !== 1'b0 || bus.index_o !== 4'd0 || bus.data_o !== 16'd0) begin
            bad++;
            $display("FAIL mid_async valid=%0b yumi=%0b idx=%0d data=%0d required 0 0 0 0",
                     bus.valid_o, bus.yumi_o, bus.index_o, bus.data_o);
        end
        @(negedge clk);
        reset_i = 1'b1;
        #1;
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_release valid_o=%0b required 0", bus.valid_o);
        end
        @(negedge clk);
        for (int i = 0; i < OS; i++) bus.data_i[i] = WS'(70 + i);
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        for (int k = 0; k < OS; k++) begin
            #1;
            total++;
            if (bus.valid_o !== 1'b1 || bus.data_o !== WS'(70 + k) || bus.index_o !== 4'(k)) begin
                bad++;
                $display("FAIL mid_restream%0d valid=%0b data=%0d idx=%0d required 1 %0d %0d",
                         k, bus.valid_o, bus.data_o, bus.index_o, 70 + k, k);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_idle valid_o=%0b required 0", bus.valid_o);
        end
        $display("test_reset_mid done");
    endtask

`ifdef ZYNET_OUTPUT_SERIALIZER_ARGMAX_EN
    task automatic test_argmax(input int vals [OS], input int exp_idx, input string nm);
        @(negedge clk);
        for (int i = 0; i < OS; i++) bus.data_i[i] = WS'(vals[i]);
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        for (int k = 0; k < OS; k++) begin
            #1;
            total++;
            if (bus.argmax_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL %s_early_pulse word%0d argmax_valid_o=%0b required 0", nm, k, bus.argmax_valid_o);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (bus.argmax_valid_o !== 1'b1 || bus.argmax_o !== 4'(exp_idx)) begin
            bad++;
            $display("FAIL %s_result argmax_valid_o=%0b argmax_o=%0d required 1 %0d",
                     nm, bus.argmax_valid_o, bus.argmax_o, exp_idx);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.argmax_valid_o !== 1'b0 || bus.argmax_o !== 4'(exp_idx)) begin
            bad++;
            $display("FAIL %s_hold argmax_valid_o=%0b argmax_o=%0d required 0 %0d",
                     nm, bus.argmax_valid_o, bus.argmax_o, exp_idx);
        end
        $display("test_argmax %s done", nm);
    endtask
`endif

    initial begin
`ifdef ZYNET_OUTPUT_SERIALIZER_ARGMAX_EN
        int v_ties [OS] = '{-5, 3, -32768, 7, 7, 0, 0, 0, 0, 0};
        int v_neg  [OS] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
`endif
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef ZYNET_OUTPUT_SERIALIZER_ARGMAX_EN
        test_argmax(v_ties, 3, "argmax_ties");
        test_argmax(v_neg, 0, "argmax_neg");
`endif
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/zynet_output_serializer.md
Name: zynet_output_serializer

Overview:
- Sink-side partner of the network's parallel result port. Consumes the OUTPUT_SIZE-word result vector through a helpful valid/yumi handshake; this block drives yumi.
- Replays the vector as one word per handshake on a valid/ready stream, flagging the last word, toward the host/UART/DMA side.
- Optionally tracks the signed argmax (predicted class) while streaming.

Parameters:
- WORD_SIZE, 16, bits per result word (signed fixed point; the fraction position does not matter here).
- OUTPUT_SIZE, 10, number of words per result vector; must be 2 or greater.
- IDX_W (localparam), $clog2(OUTPUT_SIZE), width of the word index.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset (0 = reset asserted).
- valid_i  in  1  a result vector is offered on data_i.
- data_i  in  [OUTPUT_SIZE-1:0][WORD_SIZE-1:0]  signed result vector; word k sits at data_i[k].
- yumi_o  out  1  vector consumed this cycle; never asserted unless valid_i=1.
- valid_o  out  1  data_o holds a valid word.
- ready_i  in  1  downstream accepts the word.
- data_o  out  WORD_SIZE  current word, buf[idx].
- index_o  out  IDX_W  index of the current word.
- last_o  out  1  high when idx == OUTPUT_SIZE-1 and valid_o=1.
- argmax_o  out  IDX_W  (ARGMAX_EN only) index of the maximum word.
- argmax_valid_o  out  1  (ARGMAX_EN only) one-cycle pulse when argmax_o updates.

Behaviour:
- Reset (reset_i=0, asynchronous): state=IDLE, idx=0, buf=0.
- Reset values of outputs: valid_o=0, yumi_o=0, data_o=0, index_o=0, last_o=0, argmax_o=0, argmax_valid_o=0.
- A mid-stream reset discards the vector in flight. Nothing is replayed after reset.
- FSM has two states, IDLE and STREAM.
- IDLE:
  - yumi_o = valid_i (combinational).
  - On yumi_o, latch data_i into buf, set idx=0, go to STREAM.
  - valid_o=0 in IDLE.
- STREAM:
  - valid_o=1, data_o=buf[idx], index_o=idx.
  - A handshake occurs on a cycle where valid_o=1 and ready_i=1.
  - On a handshake with idx < OUTPUT_SIZE-1: idx increments.
  - On the handshake with idx = OUTPUT_SIZE-1 (last):
    - If valid_i=1: yumi_o=1 in that same cycle, reload buf from data_i, idx=0, stay in STREAM. Back-to-back vectors have no bubble.
    - Otherwise: go to IDLE, idx=0.
  - yumi_o in STREAM = valid_i & ready_i & last_o.
- Latency and throughput:
  - Vector accepted in cycle N gives word 0 on data_o in cycle N+1.
  - Sustained rate is one word per cycle while ready_i=1.
- Backpressure: while ready_i=0, data_o, index_o and last_o hold stable. valid_o never drops once raised until the handshake.
- Input contract: data_i may change while yumi_o=0. Only the value present on the yumi_o cycle is captured.
- valid_i asserted while STREAM is not at the last word: no yumi_o; the vector waits.
- idx never exceeds OUTPUT_SIZE-1 and never wraps mid-vector.

Optional Feature:
- Macro: ZYNET_OUTPUT_SERIALIZER_ARGMAX_EN.
- Defined:
  - argmax_o and argmax_valid_o exist.
  - Running signed max and index are updated on each output handshake:
    - Word 0 loads the running max unconditionally.
    - Later words replace it only if strictly greater (signed compare), so ties keep the lowest index.
  - The cycle after the last-word handshake: argmax_o is registered and argmax_valid_o=1 for exactly one cycle.
  - argmax_o holds its value until the next vector completes.
- Undefined: both ports and all tracker logic are absent. The streaming behaviour is identical.

Decomposition:
- Shared package zynet_pkg holds:
  - the state typedef (IDLE, STREAM);
  - the default WORD_SIZE and OUTPUT_SIZE constants used by zyNet and this block.
- One sub-module is natural: argmax_tracker (WORD_SIZE, IDX_W).
  - Inputs: word, index, load, update, done.
  - Outputs: argmax index, valid pulse.
  - Instantiated only under ZYNET_OUTPUT_SERIALIZER_ARGMAX_EN.

Test Plan:
- Reset then single vector:
  - Stimulus: data_i = {9,8,...,0} (word k = k), valid_i one cycle, ready_i=1.
  - Response: yumi_o=1 in the accept cycle; data_o = 0..9 on 10 consecutive cycles; last_o only on word 9; then IDLE with valid_o=0.
- Backpressure:
  - Stimulus: ready_i toggling 1,0,0,1,... during streaming.
  - Response: data_o/index_o stable while ready_i=0; no word dropped or duplicated; 10 handshakes total.
- Back-to-back vectors:
  - Stimulus: valid_i held high with vector A and then vector B, ready_i=1.
  - Response: yumi_o pulses on the cycle of A's last handshake; B word 0 appears the next cycle; no bubble; 20 words in 20 cycles after the first accept.
- Reset mid-stream:
  - Stimulus: reset_i=0 after word 4 is accepted.
  - Response: valid_o=0 and yumi_o=0 immediately (asynchronous); after release, IDLE; the next vector streams from word 0.
- Argmax with ties and negatives (ARGMAX_EN):
  - Stimulus: words = {-5, 3, -32768, 7, 7, 0, ...}.
  - Response: argmax_o=3; argmax_valid_o high exactly one cycle after last.
  - Stimulus: all words = -1. Response: argmax_o=0.
- Protocol check:
  - yumi_o never asserted while valid_i=0.
  - valid_o never falls without a handshake.
